// File: rtl/if_stage.sv
// Instruction fetch stage: 2-credit request engine, 2-entry response FIFO, redirect/drain FSM.
// Optional macro IF_MISALIGN_TRAP_EN turns misaligned redirect targets into a trap entry.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_misalign_o
);

  localparam logic [1:0]  ST_BOOT  = 2'd0;
  localparam logic [1:0]  ST_FETCH = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        halt_q, halt_d;
  logic [31:0] instr_q [2];
  logic [31:0] pc_q [2];

  logic [31:0] tgt_pc;
  logic        tgt_mis;
  logic        redir, pop, fire, push_resp;
  logic [2:0]  used;
  logic        wr_en, wr_idx;
  logic [31:0] wr_instr, wr_pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign tgt_pc  = redirect_pc_i;
  assign tgt_mis = |redirect_pc_i[1:0];
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign tgt_pc  = {redirect_pc_i[31:2], 2'b00};
  assign tgt_mis = 1'b0;
`endif

  assign redir      = redirect_i && (state_q != ST_BOOT);
  assign id_valid_o = (cnt_q != 2'd0);
  assign pop        = id_valid_o && id_ready_i;
  // An entry leaving to decode this cycle frees its credit immediately.
  assign used       = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
  assign imem_req_o = (state_q == ST_FETCH) && !halt_q && (used < 3'd2);
  assign imem_addr_o = fetch_pc_q;
  assign fire       = imem_req_o && imem_gnt_i;
  assign push_resp  = imem_rvalid_i && (state_q == ST_FETCH) && !redir;
  assign out_d      = out_q + {1'b0, fire} - {1'b0, imem_rvalid_i};

  assign id_instr_o = instr_q[rd_ptr_q];
  assign id_pc_o    = pc_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    halt_d     = halt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q + {1'b0, push_resp} - {1'b0, pop};
    wr_en      = push_resp;
    wr_idx     = wr_ptr_q;
    wr_instr   = imem_rdata_i;
    wr_pc      = resp_pc_q;

    if (fire)      fetch_pc_d = fetch_pc_q + 32'd4;
    if (push_resp) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = ~wr_ptr_q;
    end
    if (pop)       rd_ptr_d = ~rd_ptr_q;

    // Flush after any same-cycle transfer; a misaligned target leaves one trap entry.
    if (redir) begin
      fetch_pc_d = tgt_pc;
      resp_pc_d  = tgt_pc;
      halt_d     = tgt_mis;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = tgt_mis;
      cnt_d      = {1'b0, tgt_mis};
      wr_en      = tgt_mis;
      wr_idx     = 1'b0;
      wr_instr   = NOP;
      wr_pc      = tgt_pc;
    end

    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (redir && (out_d != 2'd0)) state_d = ST_DRAIN;
      ST_DRAIN: if (out_d == 2'd0) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= 2'd0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      halt_q     <= halt_d;
    end
  end

  // NOTE: the FIFO storage is reset because the empty head drives id_instr_o/id_pc_o
  // and must read as a NOP at PC 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= NOP;
        pc_q[i]    <= 32'h0;
      end
    end else if (wr_en) begin
      instr_q[wr_idx] <= wr_instr;
      pc_q[wr_idx]    <= wr_pc;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic [1:0] mis_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      mis_q         <= 2'b00;
    else if (wr_en) mis_q[wr_idx] <= redir;
  end
  assign id_misalign_o = mis_q[rd_ptr_q];
`else
  assign id_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: in-order memory model with random latency, plus an
// epoch-based reference of which fetches reach decode and at which PC.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o, id_ready_i, id_misalign_o;
  logic [31:0] id_instr_o, id_pc_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_misalign_o(id_misalign_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  // Reference state: requests still owed by memory, tagged with the redirect epoch
  // they were issued in; stale epochs are never delivered to decode.
  req_t        memq[$];
  int          cyc, epoch, buffered, xfers;
  logic [31:0] exp_fetch, exp_id;
  bit          halted, boot;
  int          gnt_p, rv_p, rdy_p, lat_max;
  bit          redir_n;
  logic [31:0] redir_pc_n;
  int          first_grant, first_valid;
  int          xfer_cyc[$];
  logic [31:0] last_xfer_pc, post_grant_addr;
  bit          last_xfer_mis, want_grant, last_req, last_valid;
  bit          hold;
  logic [31:0] hold_pc, hold_instr;

  task automatic step();
    req_t        r;
    bit          rv, pop, fire, stale, tmis;
    logic [31:0] tgt;
    rv = (memq.size() > 0) && (cyc >= memq[0].due) && ($urandom_range(99) < rv_p);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word(memq[0].addr) : $urandom;
    id_ready_i    = ($urandom_range(99) < rdy_p);
    redirect_i    = redir_n;
    redirect_pc_i = redir_n ? redir_pc_n : $urandom;
    redir_n       = 1'b0;
    imem_gnt_i    = 1'b0;
    #1;
    pop = id_valid_o && id_ready_i;
    check("id_valid", id_valid_o, buffered != 0);
    if (id_valid_o && first_valid < 0) first_valid = cyc;
    if (hold) begin
      check("hold_pc", id_pc_o, hold_pc);
      check("hold_instr", id_instr_o, hold_instr);
    end
    if (pop) begin
      check("xfer_pc", id_pc_o, exp_id);
      check("xfer_instr", id_instr_o, halted ? NOP : word(exp_id));
      check("xfer_mis", id_misalign_o, halted);
      exp_id += 32'd4;
      buffered--;
      xfers++;
      xfer_cyc.push_back(cyc);
      last_xfer_pc  = id_pc_o;
      last_xfer_mis = id_misalign_o;
    end
    stale = 1'b0;
    foreach (memq[i]) if (memq[i].epoch != epoch) stale = 1'b1;
    if (boot || stale || halted) check("req_idle", imem_req_o, 1'b0);
    else check("req_credit", imem_req_o, (memq.size() + buffered - int'(pop)) < 2);
    last_req   = imem_req_o;
    last_valid = id_valid_o;

    imem_gnt_i = ($urandom_range(99) < gnt_p);
    fire = imem_req_o && imem_gnt_i;
    if (rv) begin
      r = memq.pop_front();
      if (r.epoch == epoch && !redirect_i) buffered++;
    end
    if (fire) begin
      check("grant_addr", imem_addr_o, exp_fetch);
      if (first_grant < 0) first_grant = cyc;
      if (want_grant) begin post_grant_addr = imem_addr_o; want_grant = 1'b0; end
      r.addr  = imem_addr_o;
      r.epoch = epoch;
      r.due   = cyc + 1 + $urandom_range(lat_max);
      memq.push_back(r);
      exp_fetch += 32'd4;
    end
    if (redirect_i) begin
`ifdef IF_MISALIGN_TRAP_EN
      tgt  = redirect_pc_i;
      tmis = (redirect_pc_i[1:0] != 2'b00);
`else
      tgt  = redirect_pc_i & ~32'h3;
      tmis = 1'b0;
`endif
      epoch++;
      buffered  = tmis ? 1 : 0;
      halted    = tmis;
      exp_fetch = tgt;
      exp_id    = tgt;
    end
    hold       = id_valid_o && !id_ready_i && !redirect_i;
    hold_pc    = id_pc_o;
    hold_instr = id_instr_o;
    boot       = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_valid", id_valid_o, 1'b0);
    check("rst_instr", id_instr_o, NOP);
    check("rst_pc", id_pc_o, 32'h0);
    check("rst_mis", id_misalign_o, 1'b0);
    memq.delete(); xfer_cyc.delete();
    epoch = 0; buffered = 0; xfers = 0; halted = 0; hold = 0; boot = 1;
    exp_fetch = RESET_PC; exp_id = RESET_PC;
    first_grant = -1; first_valid = -1; redir_n = 0; want_grant = 0;
    rst = 1'b0;
  endtask

  task automatic set_knobs(input int g, input int v, input int y, input int l);
    gnt_p = g; rv_p = v; rdy_p = y; lat_max = l;
  endtask

  // Runs until the next decode transfer; an expired budget counts as a failure.
  task automatic wait_xfer(input string tag, input logic [31:0] exp_pc);
    int n0 = xfers;
    for (int i = 0; i < 60 && xfers == n0; i++) step();
    check({tag, "_seen"}, xfers != n0, 1'b1);
    check({tag, "_pc"}, last_xfer_pc, exp_pc);
  endtask

  task automatic redirect_with_watch(input logic [31:0] pc);
    redir_n = 1'b1; redir_pc_n = pc;
  endtask

  initial begin
    int n0;
    cyc = 0;
    set_knobs(100, 100, 100, 0);
    do_reset();

    // Streaming at full rate: first decode two cycles after first grant, then back to back.
    repeat (8) step();
    check("first_valid_lat", first_valid - first_grant, 2);
    check("xfers_3", xfer_cyc.size() >= 3, 1'b1);
    if (xfer_cyc.size() >= 3) check("back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);

    // Decode stalls: two entries buffered, requests stop, head holds.
    set_knobs(100, 100, 0, 0);
    repeat (5) step();
    check("stall_req", last_req, 1'b0);
    check("stall_valid", last_valid, 1'b1);
    check("stall_two", buffered, 2);
    set_knobs(100, 100, 100, 0);
    repeat (6) step();

    // Redirect with two requests outstanding: both responses dropped.
    set_knobs(100, 0, 100, 0);
    repeat (4) step();
    check("drain_setup", memq.size(), 2);
    redirect_with_watch(32'h100);
    want_grant = 1'b0;
    step();
    want_grant = 1'b1;
    repeat (3) step();
    set_knobs(100, 100, 100, 0);
    wait_xfer("redir100", 32'h100);
    check("redir100_grant", post_grant_addr, 32'h100);

    // Redirect coinciding with a response and a decode transfer.
    set_knobs(0, 100, 100, 0);
    repeat (6) step();
    set_knobs(100, 0, 0, 0);
    repeat (2) step();
    set_knobs(0, 100, 0, 0);
    step();
    check("coinc_setup", memq.size() * 10 + buffered, 11);
    set_knobs(0, 100, 100, 0);
    redirect_with_watch(32'h200);
    n0 = xfers;
    step();
    check("coinc_once", xfers - n0, 1);
    step();
    check("coinc_empty", last_valid, 1'b0);
    set_knobs(100, 100, 100, 0);
    wait_xfer("redir200", 32'h200);

    // Misaligned redirect target.
    repeat (4) step();
    redirect_with_watch(32'h102);
    step();
    want_grant = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
    wait_xfer("mis", 32'h102);
    check("mis_flag", last_xfer_mis, 1'b1);
    repeat (5) step();
    check("mis_noreq", last_req, 1'b0);
    redirect_with_watch(32'h300);
    step();
    wait_xfer("mis_exit", 32'h300);
`else
    wait_xfer("mis", 32'h100);
    check("mis_flag", last_xfer_mis, 1'b0);
    check("mis_grant", post_grant_addr, 32'h100);
`endif

    // Random traffic with random redirects.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0)
        set_knobs($urandom_range(30, 100), $urandom_range(20, 100),
                  $urandom_range(10, 100), $urandom_range(0, 3));
      if ($urandom_range(11) == 0) begin
`ifdef IF_MISALIGN_TRAP_EN
        redirect_with_watch($urandom & 32'h0000_0FFC);
`else
        redirect_with_watch($urandom & 32'h0000_0FFF);
`endif
      end
      step();
    end

    // Reset in the middle of traffic; the memory restarts along with the stage.
    do_reset();
    set_knobs(100, 100, 100, 1);
    repeat (20) step();
    check("post_rst_pc", xfers > 0 && (xfer_cyc.size() > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 imem_req_o  output  1  instruction memory request valid.
REQ-005 imem_addr_o  output  32  request address, word aligned.
REQ-006 imem_gnt_i  input  1  request accepted this cycle when imem_req_o && imem_gnt_i.
REQ-007 imem_rvalid_i  input  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-008 imem_rdata_i  input  32  response instruction word.
REQ-009 redirect_i  input  1  control-flow redirect from EX (jal/jalr/taken branch).
REQ-010 redirect_pc_i  input  32  redirect target.
REQ-011 id_valid_o  output  1  instruction available to decode.
REQ-012 id_ready_i  input  1  decode accepts; transfer when id_valid_o && id_ready_i.
REQ-013 id_instr_o  output  32  instruction word (ir[6:0] opcode, ir[14:12] func3, ir[30] func7 to the decoder).
REQ-014 id_pc_o  output  32  PC of id_instr_o.
REQ-015 id_misalign_o  output  1  instruction-address-misaligned flag for this entry.

Function
REQ-016 Fetch PC advances by 4 on each grant; imem_addr_o equals fetch PC.
REQ-017 Credits: outstanding requests plus FIFO occupancy never exceed 2; imem_req_o low when credit exhausted.
REQ-018 Each accepted response is written to a 2-entry FIFO with response PC; response PC advances by 4 per accepted response.
REQ-019 id_valid_o is registered: FIFO not empty; first instruction visible the cycle after imem_rvalid_i (grant N, earliest rvalid N+1, id_valid_o N+2).
REQ-020 id_instr_o/id_pc_o/id_misalign_o hold stable while id_valid_o && !id_ready_i.
REQ-021 FIFO full and decode transfer same cycle: pop and push both occur, occupancy unchanged, order preserved.
REQ-022 FSM states: BOOT, FETCH, DRAIN. BOOT -> FETCH one cycle after reset release, no request in BOOT.
REQ-023 FETCH + redirect_i: FIFO flushed, fetch PC and response PC := target; -> DRAIN if outstanding (after this cycle's rvalid) > 0, else stay FETCH and request target next cycle.
REQ-024 DRAIN: imem_req_o low; responses discarded, not written to FIFO; -> FETCH when outstanding reaches 0.
REQ-025 DRAIN + redirect_i: target replaces pending PC, stay DRAIN.
REQ-026 Redirect same cycle as decode transfer: transfer completes, then flush; redirect same cycle as rvalid: response discarded.
REQ-027 Redirect same cycle as grant: granted request counted outstanding and its response discarded.
REQ-028 Outstanding counter 2 bits, saturates never (credit rule guarantees 0..2).

Reset
REQ-029 On rst_i: state BOOT, fetch PC and response PC = RESET_PC, FIFO empty, outstanding 0.
REQ-030 Reset outputs: imem_req_o 0, imem_addr_o RESET_PC, id_valid_o 0, id_instr_o 32'h0000_0013, id_pc_o 0, id_misalign_o 0.
REQ-031 Reset mid-transaction: in-flight responses arriving after release are not produced by the memory (memory reset together); no discard tracking across reset.

Configuration
REQ-032 Macro IF_MISALIGN_TRAP_EN.
REQ-033 Defined: redirect target with [1:0] != 0 pushes one entry (instr 32'h0000_0013, pc = target, id_misalign_o 1), no requests issued until next redirect_i.
REQ-034 Undefined: redirect target [1:0] forced to 2'b00; id_misalign_o tied 0; port remains.

Verification
REQ-035 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> id_pc_o 0,4,8 on consecutive cycles, first id_valid_o 2 cycles after first grant.
REQ-036 ready=0 for 5 cycles -> 2 entries buffered, imem_req_o low, id_instr_o stable; ready=1 -> entries drained in order.
REQ-037 Redirect to 32'h100 with 2 outstanding -> DRAIN, both responses dropped, next imem_addr_o 32'h100, next id_pc_o 32'h100.
REQ-038 Redirect same cycle as rvalid and decode transfer -> transferred entry consumed once, response dropped, FIFO empty.
REQ-039 IF_MISALIGN_TRAP_EN, redirect to 32'h102 -> one entry pc 32'h102, misalign 1, no further imem_req_o; without macro -> fetch from 32'h100.
